// File: rtl/txreg_arbiter_pkg.sv
// Shared types and constants for the Tx data register arbiter.
package txreg_arbiter_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

endpackage

// File: rtl/txreg_arbiter_rr_pick.sv
// Round-robin winner selection: rotate the request vector so rr_ptr sits at bit 0,
// take the lowest set bit, then rotate the index back.
module txreg_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [IDW-1:0]  winner,
  output logic            any_valid
);

  logic [NREQ-1:0] rot;
  logic [IDW-1:0]  off;

  always_comb begin
    rot = '0;
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = i + int'(rr_ptr);
      if (j >= NREQ) j = j - NREQ;
      rot[i] = req[j];
    end
  end

  always_comb begin
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDW'(i);
    end
  end

  always_comb begin
    int s;
    s = int'(rr_ptr) + int'(off);
    if (s >= NREQ) s = s - NREQ;
    winner = IDW'(s);
  end

  assign any_valid = |req;

endmodule

// File: rtl/txreg_arbiter.sv
// Round-robin sequencer sharing the Tx data register among NREQ byte producers.
//  state    | meaning
//  ST_IDLE  | waiting for a request while enabled and the register is not busy
//  ST_ISSUE | write strobe held, waiting for accept or timeout
//  ST_ACK   | accept seen, ack pulse out, pointer advances on exit
module txreg_arbiter
  import txreg_arbiter_pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int TIMEOUT = 16,
  localparam int IDW     = $clog2(NREQ)
) (
  input  logic                     i_Pclk,
  input  logic                     i_Reset_n,
  input  logic                     i_Enable,
  input  logic [NREQ-1:0]          i_Req,
  input  logic [BYTE_W*NREQ-1:0]   i_Data,
  output logic [NREQ-1:0]          o_Ack,
  output logic [NREQ-1:0]          o_Nak,
  output logic [IDW-1:0]           o_Grant_Id,
  output logic                     o_Active,
  output logic                     o_Reg_En,
  output logic [BYTE_W-1:0]        o_Reg_Data,
  input  logic                     i_Reg_Ready,
  input  logic                     i_Reg_Busy
);

  localparam int TW = $clog2(TIMEOUT);

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]    grant_d;
  logic [BYTE_W-1:0] data_d, data_sel;
  logic [NREQ-1:0]   ack_d, nak_d, grant_oh;
  logic [IDW-1:0]    next_ptr;
  logic              en_d;
  logic [IDW-1:0]    winner;
  logic              any_valid;

  txreg_arbiter_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req       (i_Req),
    .rr_ptr    (rr_ptr_q),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_comb begin
    data_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (IDW'(k) == winner) data_sel = i_Data[BYTE_W*k +: BYTE_W];
    end
  end

  assign grant_oh = {{(NREQ-1){1'b0}}, 1'b1} << o_Grant_Id;
  assign next_ptr = (o_Grant_Id == IDW'(NREQ - 1)) ? '0 : o_Grant_Id + 1'b1;

  // Timer is a down-counter loaded at grant; reaching zero while still in ISSUE gives
  // exactly TIMEOUT cycles of strobe before the NAK.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = o_Grant_Id;
    data_d   = o_Reg_Data;
    en_d     = 1'b0;
    ack_d    = '0;
    nak_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (i_Enable && !i_Reg_Busy && any_valid) begin
          state_d = ST_ISSUE;
          grant_d = winner;
          data_d  = data_sel;
          en_d    = 1'b1;
          timer_d = TW'(TIMEOUT - 1);
        end
      end
      ST_ISSUE: begin
        if (i_Reg_Ready) begin
          state_d = ST_ACK;
          ack_d   = grant_oh;
        end else if (timer_q == '0) begin
          state_d  = ST_IDLE;
          nak_d    = grant_oh;
          rr_ptr_d = next_ptr;
        end else begin
          en_d    = 1'b1;
          timer_d = timer_q - 1'b1;
        end
      end
      ST_ACK: begin
        state_d  = ST_IDLE;
        rr_ptr_d = next_ptr;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      rr_ptr_q   <= '0;
      o_Grant_Id <= '0;
      o_Reg_Data <= '0;
      o_Reg_En   <= 1'b0;
      o_Ack      <= '0;
      o_Nak      <= '0;
      o_Active   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      rr_ptr_q   <= rr_ptr_d;
      o_Grant_Id <= grant_d;
      o_Reg_Data <= data_d;
      o_Reg_En   <= en_d;
      o_Ack      <= ack_d;
      o_Nak      <= nak_d;
      o_Active   <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_txreg_arbiter.sv
// Directed bench for txreg_arbiter (NREQ=4, TIMEOUT=16) with hand-computed expectations.
module tb_txreg_arbiter;

  logic        i_Pclk;
  logic        i_Reset_n;
  logic        i_Enable;
  logic [3:0]  i_Req;
  logic [31:0] i_Data;
  logic [3:0]  o_Ack;
  logic [3:0]  o_Nak;
  logic [1:0]  o_Grant_Id;
  logic        o_Active;
  logic        o_Reg_En;
  logic [7:0]  o_Reg_Data;
  logic        i_Reg_Ready;
  logic        i_Reg_Busy;

  int n_cmp = 0;
  int n_err = 0;

  txreg_arbiter #(.NREQ(4), .TIMEOUT(16)) dut (
    .i_Pclk      (i_Pclk),
    .i_Reset_n   (i_Reset_n),
    .i_Enable    (i_Enable),
    .i_Req       (i_Req),
    .i_Data      (i_Data),
    .o_Ack       (o_Ack),
    .o_Nak       (o_Nak),
    .o_Grant_Id  (o_Grant_Id),
    .o_Active    (o_Active),
    .o_Reg_En    (o_Reg_En),
    .o_Reg_Data  (o_Reg_Data),
    .i_Reg_Ready (i_Reg_Ready),
    .i_Reg_Busy  (i_Reg_Busy)
  );

  initial i_Pclk = 1'b0;
  always #5 i_Pclk = ~i_Pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_Pclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] exp_id;
    logic [7:0] exp_byte;

    i_Reset_n   = 1'b0;
    i_Enable    = 1'b1;
    i_Req       = '0;
    i_Data      = '0;
    i_Reg_Ready = 1'b0;
    i_Reg_Busy  = 1'b0;
    #12;
    chk("rst_en",     o_Reg_En,   0);
    chk("rst_active", o_Active,   0);
    chk("rst_grant",  o_Grant_Id, 0);
    chk("rst_data",   o_Reg_Data, 0);
    chk("rst_ack",    o_Ack,      0);
    chk("rst_nak",    o_Nak,      0);
    @(negedge i_Pclk);
    i_Reset_n = 1'b1;

    // single request from requester 2
    i_Data = 32'h44A5_2211;
    i_Req  = 4'b0100;
    step();
    chk("t1_en",     o_Reg_En,   1);
    chk("t1_data",   o_Reg_Data, 8'hA5);
    chk("t1_grant",  o_Grant_Id, 2);
    chk("t1_active", o_Active,   1);
    i_Data = 32'h00FF_0000;
    step();
    chk("t1_data_hold", o_Reg_Data, 8'hA5);
    chk("t1_no_ack",    o_Ack,      0);
    i_Reg_Ready = 1'b1;
    step();
    i_Reg_Ready = 1'b0;
    chk("t1_ack",    o_Ack,    4'b0100);
    chk("t1_en_off", o_Reg_En, 0);
    i_Req = '0;
    step();
    chk("t1_ack_pulse", o_Ack,    0);
    chk("t1_idle",      o_Active, 0);

    i_Reset_n = 1'b0;
    #2;
    i_Reset_n = 1'b1;

    // all requesters held: strict rotation from pointer 0
    i_Data = 32'hD3C2_B1A0;
    i_Req  = 4'hF;
    for (int op = 0; op < 8; op++) begin
      exp_id   = 2'(op % 4);
      exp_byte = 8'hA0 + 8'h11 * 8'(op % 4);
      step();
      chk("t2_grant", o_Grant_Id, exp_id);
      chk("t2_data",  o_Reg_Data, exp_byte);
      chk("t2_en",    o_Reg_En,   1);
      step();
      i_Reg_Ready = 1'b1;
      step();
      i_Reg_Ready = 1'b0;
      chk("t2_ack", o_Ack, 4'b0001 << exp_id);
      chk("t2_nak", o_Nak, 0);
      step();
      chk("t2_ack_pulse", o_Ack, 0);
    end

    // busy blocks grants; ready while idle is ignored
    i_Reg_Busy = 1'b1;
    i_Req      = 4'b0001;
    repeat (3) begin
      step();
      chk("t3_busy_en",     o_Reg_En, 0);
      chk("t3_busy_active", o_Active, 0);
    end
    i_Reg_Ready = 1'b1;
    step();
    i_Reg_Ready = 1'b0;
    chk("t3_idle_ready_ack", o_Ack,    0);
    chk("t3_idle_ready_en",  o_Reg_En, 0);
    i_Reg_Busy = 1'b0;
    step();
    chk("t3_grant_en", o_Reg_En,   1);
    chk("t3_grant_id", o_Grant_Id, 0);

    // never ready: strobe lasts 16 cycles then NAK
    for (int c = 2; c <= 16; c++) begin
      step();
      chk("t4_en_hold", o_Reg_En, 1);
      chk("t4_no_nak",  o_Nak,    0);
    end
    step();
    chk("t4_en_off", o_Reg_En, 0);
    chk("t4_nak",    o_Nak,    4'b0001);
    chk("t4_ack",    o_Ack,    0);
    chk("t4_active", o_Active, 0);
    i_Req = 4'b0011;
    step();
    chk("t4_next_grant", o_Grant_Id, 1);
    chk("t4_next_en",    o_Reg_En,   1);

    // enable drops mid-op: op completes, no new grants
    i_Enable = 1'b0;
    step();
    i_Reg_Ready = 1'b1;
    step();
    i_Reg_Ready = 1'b0;
    chk("t5_ack", o_Ack, 4'b0010);
    i_Req = 4'hF;
    step();
    chk("t5_ack_pulse", o_Ack,    0);
    chk("t5_active",    o_Active, 0);
    repeat (4) begin
      step();
      chk("t5_dis_en",     o_Reg_En, 0);
      chk("t5_dis_active", o_Active, 0);
    end
    i_Enable = 1'b1;
    step();
    chk("t5_reen_grant", o_Grant_Id, 2);
    chk("t5_reen_data",  o_Reg_Data, 8'hC2);
    chk("t5_reen_en",    o_Reg_En,   1);

    // async reset mid-ISSUE
    step();
    #2;
    i_Reset_n = 1'b0;
    #1;
    chk("t6_rst_en",     o_Reg_En,   0);
    chk("t6_rst_active", o_Active,   0);
    chk("t6_rst_grant",  o_Grant_Id, 0);
    chk("t6_rst_data",   o_Reg_Data, 0);
    i_Req = '0;
    #1;
    i_Reset_n = 1'b1;
    repeat (3) begin
      step();
      chk("t6_no_ack",    o_Ack,    0);
      chk("t6_no_nak",    o_Nak,    0);
      chk("t6_no_active", o_Active, 0);
    end
    i_Req = 4'b1000;
    step();
    chk("t6_grant_after", o_Grant_Id, 3);
    chk("t6_en_after",    o_Reg_En,   1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
